// File: rtl/rx_byte_fifo.sv
// -----------------------------------------------------------------------------
// rx_byte_fifo
//   Receive-side byte buffer for the UART receiver. A byte is captured on the
//   rising edge of the receiver's done strobe and stored in a 2**DEPTH_LOG2
//   entry FIFO. The host reads it through a first-word-fall-through
//   valid/ready interface. A byte that arrives while the FIFO is full, with
//   no pop in the same cycle, is dropped and sets a sticky overflow flag.
//
// Parameters
//   DEPTH_LOG2      log2 of FIFO depth (default 4 -> 16 entries)
//   WATERMARK       almost-full threshold in entries (only with the macro)
//
// Ports
//   clk             system clock, all logic on posedge
//   reset           asynchronous, active-high reset
//   i_rx_done       receiver byte-complete strobe (pulse or level)
//   i_rx_data       received byte, valid while i_rx_done is high
//   o_data          head-of-FIFO byte, 8'h00 when o_valid is low
//   o_valid         FIFO non-empty
//   i_ready         consumer takes o_data this cycle
//   o_count         current occupancy, 0..DEPTH
//   o_full          occupancy == DEPTH
//   o_empty         occupancy == 0
//   o_overflow      sticky overrun flag
//   i_clr_overflow  synchronous clear of o_overflow
//   o_almost_full   registered (occupancy >= WATERMARK), only with the macro
//
// Configuration macro
//   RX_FIFO_WATERMARK_EN  adds the WATERMARK parameter, the o_almost_full
//                         port and its comparator.
// -----------------------------------------------------------------------------
module rx_byte_fifo #(
  parameter int DEPTH_LOG2 = 4
`ifdef RX_FIFO_WATERMARK_EN
  , parameter int WATERMARK = 12
`endif
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  i_rx_done,
  input  logic [7:0]            i_rx_data,
  output logic [7:0]            o_data,
  output logic                  o_valid,
  input  logic                  i_ready,
  output logic [DEPTH_LOG2:0]   o_count,
  output logic                  o_full,
  output logic                  o_empty,
  output logic                  o_overflow,
  input  logic                  i_clr_overflow
`ifdef RX_FIFO_WATERMARK_EN
  , output logic                o_almost_full
`endif
);

  localparam int DEPTH = 2 ** DEPTH_LOG2;
  localparam int PW    = DEPTH_LOG2 + 1;

  logic [7:0]            mem [DEPTH];
  logic [PW-1:0]         wr_ptr;
  logic [PW-1:0]         rd_ptr;
  logic [PW-1:0]         count;
  logic                  r_done_d;
  logic                  push_req;
  logic                  pop;
  logic                  do_push;
  logic                  overrun;
  logic                  full;
  logic                  empty;

  // r_done_d resets to 1 so a done level already high at reset release is
  // not mistaken for a new byte.
  assign push_req = i_rx_done & ~r_done_d;

  // Pointers carry one extra wrap bit: equal pointers mean empty, equal
  // index with differing wrap bit means full.
  assign count = wr_ptr - rd_ptr;
  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[DEPTH_LOG2] != rd_ptr[DEPTH_LOG2]) &&
                 (wr_ptr[DEPTH_LOG2-1:0] == rd_ptr[DEPTH_LOG2-1:0]);

  // A pop frees the head slot this same edge, so a full FIFO can still
  // accept a byte when the consumer reads at the same time.
  assign pop     = ~empty & i_ready;
  assign do_push = push_req & (~full | pop);
  assign overrun = push_req & full & ~pop;

  assign o_valid = ~empty;
  assign o_empty = empty;
  assign o_full  = full;
  assign o_count = count;
  assign o_data  = empty ? 8'h00 : mem[rd_ptr[DEPTH_LOG2-1:0]];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_done_d <= 1'b1;
    end else begin
      r_done_d <= i_rx_done;
    end
  end

  // Storage is not reset; stale contents are unreachable once the
  // pointers are cleared.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr[DEPTH_LOG2-1:0]] <= i_rx_data;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
    end
  end

  // A new overrun takes priority over a clear in the same cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      o_overflow <= 1'b0;
    end else if (overrun) begin
      o_overflow <= 1'b1;
    end else if (i_clr_overflow) begin
      o_overflow <= 1'b0;
    end
  end

`ifdef RX_FIFO_WATERMARK_EN
  logic [PW-1:0] count_next;

  // Compare against the occupancy this edge will produce so the flag
  // changes on the same edge as o_count.
  assign count_next = count + PW'(do_push) - PW'(pop);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      o_almost_full <= 1'b0;
    end else begin
      o_almost_full <= (count_next >= PW'(WATERMARK));
    end
  end
`endif

endmodule

// File: tb/tb_rx_byte_fifo.sv
// -----------------------------------------------------------------------------
// tb_rx_byte_fifo
//   Self-checking bench for rx_byte_fifo. A driver applies directed and
//   random stimulus on each cycle and updates a queue-based reference model.
//   Every byte the model accepts goes into a scoreboard queue. A monitor on
//   the falling edge compares the occupancy and flags against the model, and
//   pops the scoreboard whenever the DUT hands a byte to the consumer.
// -----------------------------------------------------------------------------
module tb_rx_byte_fifo;

  localparam int DEPTH_LOG2 = 4;
  localparam int DEPTH      = 16;
`ifdef RX_FIFO_WATERMARK_EN
  localparam int WATERMARK  = 12;
`endif

  logic                clk;
  logic                reset;
  logic                i_rx_done;
  logic [7:0]          i_rx_data;
  logic [7:0]          o_data;
  logic                o_valid;
  logic                i_ready;
  logic [DEPTH_LOG2:0] o_count;
  logic                o_full;
  logic                o_empty;
  logic                o_overflow;
  logic                i_clr_overflow;
`ifdef RX_FIFO_WATERMARK_EN
  logic                o_almost_full;
`endif

  rx_byte_fifo #(
    .DEPTH_LOG2(DEPTH_LOG2)
`ifdef RX_FIFO_WATERMARK_EN
    , .WATERMARK(WATERMARK)
`endif
  ) dut (
    .clk(clk),
    .reset(reset),
    .i_rx_done(i_rx_done),
    .i_rx_data(i_rx_data),
    .o_data(o_data),
    .o_valid(o_valid),
    .i_ready(i_ready),
    .o_count(o_count),
    .o_full(o_full),
    .o_empty(o_empty),
    .o_overflow(o_overflow),
    .i_clr_overflow(i_clr_overflow)
`ifdef RX_FIFO_WATERMARK_EN
    , .o_almost_full(o_almost_full)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Scoreboard: bytes the DUT must deliver, oldest first.
  logic [7:0] exp_q [$];

  // Reference model state: occupancy and overflow now (cur_*) and after the
  // coming edge (nxt_*); prev_done tracks the last sampled done level.
  int   cur_cnt, nxt_cnt;
  bit   cur_ovf, nxt_ovf;
  bit   prev_done;
`ifdef RX_FIFO_WATERMARK_EN
  bit   cur_af, nxt_af;
`endif

  int   n_checks;
  int   n_errors;

  task automatic check_value(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // One clock cycle: commit the prediction for the edge just taken, drive
  // new inputs, then predict the effect of the next edge.
  task automatic apply_cycle(input bit done, input logic [7:0] data,
                             input bit ready, input bit clr);
    bit push_req;
    bit pop;
    int cnt;
    @(posedge clk);
    cur_cnt = nxt_cnt;
    cur_ovf = nxt_ovf;
`ifdef RX_FIFO_WATERMARK_EN
    cur_af  = nxt_af;
`endif
    #2;
    i_rx_done      = done;
    i_rx_data      = data;
    i_ready        = ready;
    i_clr_overflow = clr;
    push_req  = done && !prev_done;
    prev_done = done;
    pop       = (cur_cnt > 0) && ready;
    cnt       = cur_cnt - (pop ? 1 : 0);
    nxt_ovf   = clr ? 1'b0 : cur_ovf;
    if (push_req) begin
      if (cnt < DEPTH) begin
        exp_q.push_back(data);
        cnt++;
      end else begin
        nxt_ovf = 1'b1;
      end
    end
    nxt_cnt = cnt;
`ifdef RX_FIFO_WATERMARK_EN
    nxt_af  = (cnt >= WATERMARK);
`endif
  endtask

  // Asserted and released away from the clock edge; the model is emptied
  // at once because the reset is asynchronous.
  task automatic do_reset(input bit done_level);
    @(posedge clk);
    #2;
    reset     = 1'b1;
    i_rx_done = done_level;
    i_ready   = 1'b0;
    exp_q.delete();
    cur_cnt = 0; nxt_cnt = 0;
    cur_ovf = 0; nxt_ovf = 0;
    prev_done = 1'b1;
`ifdef RX_FIFO_WATERMARK_EN
    cur_af = 0; nxt_af = 0;
`endif
    repeat (2) @(posedge clk);
    #2;
    reset = 1'b0;
  endtask

  task automatic push_byte(input logic [7:0] b);
    apply_cycle(1'b1, b, 1'b0, 1'b0);
    apply_cycle(1'b0, b, 1'b0, 1'b0);
  endtask

  task automatic drain(input int n);
    for (int k = 0; k < n; k++) begin
      apply_cycle(1'b0, 8'h00, 1'b1, 1'b0);
    end
  endtask

  // Monitor: compare state each cycle and consume the scoreboard on every
  // handshake the DUT presents.
  always @(negedge clk) begin
    check_value("count", int'(o_count), cur_cnt);
    check_value("empty", int'(o_empty), int'(cur_cnt == 0));
    check_value("full", int'(o_full), int'(cur_cnt == DEPTH));
    check_value("valid", int'(o_valid), int'(cur_cnt != 0));
    check_value("overflow", int'(o_overflow), int'(cur_ovf));
`ifdef RX_FIFO_WATERMARK_EN
    check_value("almost_full", int'(o_almost_full), int'(cur_af));
`endif
    if (o_valid && i_ready) begin
      if (exp_q.size() == 0) begin
        check_value("unexpected_pop", int'(o_data), -1);
      end else begin
        check_value("data", int'(o_data), int'(exp_q.pop_front()));
      end
    end else if (!o_valid) begin
      check_value("idle_data", int'(o_data), 0);
    end
  end

  initial begin
    int rate;
    n_checks = 0;
    n_errors = 0;
    reset = 1'b1;
    i_rx_done = 1'b0;
    i_rx_data = 8'h00;
    i_ready = 1'b0;
    i_clr_overflow = 1'b0;
    cur_cnt = 0; nxt_cnt = 0;
    cur_ovf = 0; nxt_ovf = 0;
    prev_done = 1'b1;
`ifdef RX_FIFO_WATERMARK_EN
    cur_af = 0; nxt_af = 0;
`endif
    repeat (2) @(posedge clk);
    #2;
    reset = 1'b0;

    $display("[TB] single byte push and pop");
    apply_cycle(1'b0, 8'h00, 1'b0, 1'b0);
    push_byte(8'hA5);
    drain(2);

    $display("[TB] done held high for ten cycles");
    for (int k = 0; k < 10; k++) apply_cycle(1'b1, 8'h3C, 1'b0, 1'b0);
    apply_cycle(1'b0, 8'h3C, 1'b0, 1'b0);
    drain(2);

    $display("[TB] fill, overrun, drain");
    for (int k = 0; k < 16; k++) push_byte(8'(k));
    push_byte(8'hFF);
    drain(17);

    $display("[TB] push and pop on a full FIFO");
    for (int k = 0; k < 16; k++) push_byte(8'(8'h40 + k));
    apply_cycle(1'b1, 8'h77, 1'b1, 1'b0);
    apply_cycle(1'b0, 8'h77, 1'b0, 1'b0);
    drain(17);

    $display("[TB] overflow clear versus new overrun");
    for (int k = 0; k < 16; k++) push_byte(8'(8'h80 + k));
    push_byte(8'hFF);
    apply_cycle(1'b1, 8'hEE, 1'b0, 1'b1);
    apply_cycle(1'b0, 8'hEE, 1'b0, 1'b1);
    apply_cycle(1'b0, 8'hEE, 1'b0, 1'b0);
    drain(17);

    $display("[TB] watermark crossing and reset with entries");
    for (int k = 0; k < 12; k++) push_byte(8'(8'hC0 + k));
    apply_cycle(1'b0, 8'h00, 1'b1, 1'b0);
    apply_cycle(1'b0, 8'h00, 1'b0, 1'b0);
    drain(11);
    for (int k = 0; k < 5; k++) push_byte(8'(8'hD0 + k));
    do_reset(1'b1);
    apply_cycle(1'b1, 8'h99, 1'b0, 1'b0);
    apply_cycle(1'b1, 8'h99, 1'b0, 1'b0);
    apply_cycle(1'b0, 8'h99, 1'b0, 1'b0);
    push_byte(8'h5A);
    drain(2);

    $display("[TB] random traffic");
    rate = 50;
    for (int i = 0; i < 2000; i++) begin
      if (i % 200 == 0) rate = $urandom_range(5, 95);
      if (i == 1000) do_reset($urandom_range(0, 1) == 1);
      apply_cycle($urandom_range(0, 2) != 0, 8'($urandom_range(0, 255)),
                  $urandom_range(0, 99) < rate, $urandom_range(0, 15) == 0);
    end
    drain(DEPTH + 2);
    @(negedge clk);
    check_value("leftover", exp_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
